// File: rtl/lru_tracker.sv
// -----------------------------------------------------------------------------
// lru_tracker
//
// True-LRU replacement tracker for a set-associative cache controller. For each
// set it holds a valid vector and a full recency ranking of the ways
// (rank 0 = MRU, NUM_WAYS-1 = LRU). The ranks of one set always form a
// permutation of 0..NUM_WAYS-1. One request is accepted per cycle. The state
// update and the response register on the same edge, so a request always sees
// the effect of every earlier request.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-high reset
//   req_valid_i    request strobe (never back-pressured)
//   req_op_i       00 NOP, 01 TOUCH, 10 ALLOC, 11 INVALIDATE
//   req_set_i      target set
//   req_way_i      target way for TOUCH / INVALIDATE (ignored for ALLOC)
//   rsp_valid_o    response for the previous cycle's request
//   rsp_way_o      one-hot way selected or affected
//   rsp_way_idx_o  binary index of rsp_way_o
//   rsp_hit_o      TOUCH landed on a valid way
//   rsp_evict_o    ALLOC replaced a valid way
//   set_full_o     all ways of the responded set valid after the operation
// -----------------------------------------------------------------------------
module lru_tracker #(
  parameter int NUM_WAYS = 4,
  parameter int NUM_SETS = 8,
  parameter int WAY_W    = $clog2(NUM_WAYS),
  parameter int SET_W    = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid_i,
  input  logic [1:0]          req_op_i,
  input  logic [SET_W-1:0]    req_set_i,
  input  logic [WAY_W-1:0]    req_way_i,
  output logic                rsp_valid_o,
  output logic [NUM_WAYS-1:0] rsp_way_o,
  output logic [WAY_W-1:0]    rsp_way_idx_o,
  output logic                rsp_hit_o,
  output logic                rsp_evict_o,
  output logic                set_full_o
);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_TOUCH = 2'b01;
  localparam logic [1:0] OP_ALLOC = 2'b10;
  localparam logic [1:0] OP_INVAL = 2'b11;

  localparam logic [WAY_W-1:0] RANK_MRU = '0;
  localparam logic [WAY_W-1:0] RANK_LRU = WAY_W'(NUM_WAYS - 1);

  // ---------------------------------------------------------------------------
  // Per-set state
  // ---------------------------------------------------------------------------
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  logic [WAY_W-1:0]    rank_q  [NUM_SETS][NUM_WAYS];

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic accept;
  logic is_touch;
  logic is_alloc;
  logic is_inval;

  assign accept   = req_valid_i && (req_op_i != OP_NOP);
  assign is_touch = accept && (req_op_i == OP_TOUCH);
  assign is_alloc = accept && (req_op_i == OP_ALLOC);
  assign is_inval = accept && (req_op_i == OP_INVAL);

  // ---------------------------------------------------------------------------
  // Read the addressed set
  // ---------------------------------------------------------------------------
  logic [NUM_WAYS-1:0] cur_valid;
  logic [WAY_W-1:0]    cur_rank [NUM_WAYS];

  always_comb begin
    cur_valid = valid_q[req_set_i];
    for (int i = 0; i < NUM_WAYS; i++) begin
      cur_rank[i] = rank_q[req_set_i][i];
    end
  end

  // ---------------------------------------------------------------------------
  // Victim selection: lowest-index invalid way, else the way ranked LRU
  // ---------------------------------------------------------------------------
  logic             have_invalid;
  logic [WAY_W-1:0] inv_idx;
  logic [WAY_W-1:0] lru_idx;

  always_comb begin
    have_invalid = 1'b0;
    inv_idx      = '0;
    // Scan downward so the last hit (lowest index) wins.
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!cur_valid[i]) begin
        have_invalid = 1'b1;
        inv_idx      = WAY_W'(i);
      end
    end
  end

  always_comb begin
    lru_idx = '0;
    // Exactly one way carries the LRU rank because ranks are a permutation.
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (cur_rank[i] == RANK_LRU) begin
        lru_idx = WAY_W'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Target way and its current state
  // ---------------------------------------------------------------------------
  logic [WAY_W-1:0]    tgt_way;
  logic                tgt_valid;
  logic [WAY_W-1:0]    tgt_rank;
  logic [NUM_WAYS-1:0] tgt_onehot;
  logic                do_promote;
  logic                do_demote;

  assign tgt_way    = is_alloc ? (have_invalid ? inv_idx : lru_idx) : req_way_i;
  assign tgt_valid  = cur_valid[tgt_way];
  assign tgt_rank   = cur_rank[tgt_way];
  assign tgt_onehot = {{(NUM_WAYS-1){1'b0}}, 1'b1} << tgt_way;

  // A TOUCH on an invalid way leaves the ranking alone; INVALIDATE demotes
  // even an already-invalid way so it stays first in line for reuse.
  assign do_promote = is_alloc || (is_touch && tgt_valid);
  assign do_demote  = is_inval;

  // ---------------------------------------------------------------------------
  // Next state of the addressed set
  // ---------------------------------------------------------------------------
  logic [NUM_WAYS-1:0] nxt_valid;
  logic [WAY_W-1:0]    nxt_rank [NUM_WAYS];

  always_comb begin
    nxt_valid = cur_valid;
    if (is_alloc) nxt_valid[tgt_way] = 1'b1;
    if (is_inval) nxt_valid[tgt_way] = 1'b0;
  end

  always_comb begin
    for (int i = 0; i < NUM_WAYS; i++) begin
      nxt_rank[i] = cur_rank[i];
      if (do_promote) begin
        if (WAY_W'(i) == tgt_way) begin
          nxt_rank[i] = RANK_MRU;
        end else if (cur_rank[i] < tgt_rank) begin
          nxt_rank[i] = cur_rank[i] + 1'b1;
        end
      end else if (do_demote) begin
        if (WAY_W'(i) == tgt_way) begin
          nxt_rank[i] = RANK_LRU;
        end else if (cur_rank[i] > tgt_rank) begin
          nxt_rank[i] = cur_rank[i] - 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          rank_q[s][w] <= WAY_W'(w);
        end
      end
      rsp_valid_o   <= 1'b0;
      rsp_way_o     <= '0;
      rsp_way_idx_o <= '0;
      rsp_hit_o     <= 1'b0;
      rsp_evict_o   <= 1'b0;
      set_full_o    <= 1'b0;
    end else begin
      if (accept) begin
        valid_q[req_set_i] <= nxt_valid;
        for (int w = 0; w < NUM_WAYS; w++) begin
          rank_q[req_set_i][w] <= nxt_rank[w];
        end
      end
      rsp_valid_o   <= accept;
      rsp_way_o     <= accept ? tgt_onehot : '0;
      rsp_way_idx_o <= accept ? tgt_way : '0;
      rsp_hit_o     <= is_touch && tgt_valid;
      rsp_evict_o   <= is_alloc && !have_invalid;
      set_full_o    <= accept && (&nxt_valid);
    end
  end

endmodule

// File: doc/lru_tracker.md
Name: lru_tracker

Overview:
- Multi-set true-LRU replacement tracker for a set-associative cache controller.
- Keeps a per-set valid vector and a full recency ranking of all ways.
- Serves TOUCH, ALLOC and INVALIDATE requests, one per cycle, and returns a registered response one cycle later.
- ALLOC picks an invalid way first; otherwise it picks the true least-recently-used way, not a rotating pointer.

Parameters:
- NUM_WAYS, 4: ways per set. Must be a power of 2 and at least 2.
- NUM_SETS, 8: number of independently tracked sets. Must be a power of 2 and at least 1.
- WAY_W, $clog2(NUM_WAYS): derived; way index and rank width.
- SET_W, $clog2(NUM_SETS) (1 when NUM_SETS==1): derived; set index width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valid_i  input  1  request strobe; one request accepted per cycle, never back-pressured
- req_op_i  input  2  2'b00 NOP, 2'b01 TOUCH, 2'b10 ALLOC, 2'b11 INVALIDATE
- req_set_i  input  SET_W  target set
- req_way_i  input  WAY_W  target way for TOUCH/INVALIDATE; ignored for ALLOC
- rsp_valid_o  output  1  response for the request of the previous cycle
- rsp_way_o  output  NUM_WAYS  one-hot way selected or affected
- rsp_way_idx_o  output  WAY_W  binary index of rsp_way_o
- rsp_hit_o  output  1  TOUCH landed on a valid way
- rsp_evict_o  output  1  ALLOC replaced a valid way (victim writeback/eviction needed)
- set_full_o  output  1  all ways of the responded set are valid after the operation

Behaviour:
- State per set:
  - valid[NUM_WAYS].
  - rank[way], WAY_W bits. 0 = MRU, NUM_WAYS-1 = LRU.
  - Ranks in a set are always a permutation of 0..NUM_WAYS-1.
- Reset (async, immediate):
  - All valid bits = 0.
  - rank[i] = i in every set.
  - All outputs = 0.
  - A request in flight when reset asserts is dropped; no response is produced.
- Request accepted when req_valid_i=1 and op != NOP.
  - NOP, or req_valid_i=0: no state change, and rsp_valid_o=0 next cycle.
- Latency and ordering:
  - State updates and the response both register on the same clk edge.
  - rsp_* is valid exactly one cycle after the request.
  - A request always reads state that includes all earlier requests, so back-to-back requests to the same set need no stall.
- MRU promotion of way w with old rank r:
  - Every way with rank < r gets rank+1.
  - w gets rank 0.
  - Other ways are unchanged.
- LRU demotion of way w with old rank r:
  - Every way with rank > r gets rank-1.
  - w gets rank NUM_WAYS-1.
- TOUCH way w:
  - If valid[w]: MRU-promote w; rsp_hit_o=1.
  - If not valid[w]: no state change; rsp_hit_o=0.
  - rsp_way_o = onehot(w); rsp_evict_o=0.
- ALLOC:
  - If any way is invalid, the victim is the lowest-index invalid way; rsp_evict_o=0.
  - Otherwise the victim is the way with rank NUM_WAYS-1; rsp_evict_o=1.
  - Victim: valid set to 1, MRU-promoted.
  - rsp_way_o = onehot(victim); rsp_hit_o=0.
- INVALIDATE way w:
  - valid[w] is cleared; w is LRU-demoted, including when w was already invalid.
  - rsp_way_o = onehot(w); rsp_hit_o=0; rsp_evict_o=0.
- set_full_o: AND of the post-update valid bits of the responded set.
- When rsp_valid_o=0, all other rsp_* outputs and set_full_o are 0.
- Operations on different sets are fully independent.

Test Plan:
- Reset, then ALLOC set 0 four times (NUM_WAYS=4) -> ways 0,1,2,3 with evict=0. set_full_o=0,0,0,1. Ranks become way3=0, way2=1, way1=2, way0=3.
- Continue with TOUCH set 0 way 0, then ALLOC set 0 -> TOUCH gives hit=1. ALLOC returns way 1 (rsp_way_o=4'b0010) with evict=1.
- INVALIDATE set 0 way 2, then ALLOC set 0 -> ALLOC returns way 2 with evict=0, and set_full_o=1 again.
- TOUCH set 3 way 1 on a fresh set -> hit=0 and no state change. A following ALLOC set 3 returns way 0.
- Back-to-back: ALLOC set 5 on consecutive cycles with no idle cycle -> ways 0 then 1, each response arriving exactly one cycle after its request. Interleaved ALLOC set 6 returns way 0, independent of set 5.
- Assert reset mid-stream with a request pending -> rsp_valid_o=0 immediately. After release, ALLOC on a previously full set returns way 0 with evict=0.
